cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DEPTH, 2, entries in each per-FU result queue (legal 2..4).
REQ-002 Parameter PREG_W, 7, physical-register tag width.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Ports alu_valid/alu_pd/alu_rob/alu_data  in  1/PREG_W/5/32  ALU result offer: valid, destination preg, ROB tag, value.
REQ-006 Port alu_ready  out  1  ALU queue can accept this cycle.
REQ-007 Ports mem_valid/mem_pd/mem_rob/mem_data  in  1/PREG_W/5/32  load/store unit result offer.
REQ-008 Port mem_ready  out  1  MEM queue can accept this cycle.
REQ-009 Ports br_valid/br_pd/br_rob/br_data  in  1/PREG_W/5/32  branch unit result offer (link value in data).
REQ-010 Port br_ready  out  1  BR queue can accept this cycle.
REQ-011 Ports flush/flush_tag  in  1/5  mispredict kill request; ROB tag of the mispredicted branch.
REQ-012 Port rob_head  in  5  current ROB head tag, used for age.
REQ-013 Ports cdb_valid/cdb_pd/cdb_rob/cdb_data  out  1/PREG_W/5/32  registered common-data-bus broadcast.
REQ-014 Port cdb_src  out  2  granted source: 0 ALU, 1 MEM, 2 BR; 3 unused.

Function
REQ-015 Each FU owns a DEPTH-entry FIFO; push occurs on an edge where x_valid && x_ready.
REQ-016 x_ready SHALL equal (count_x < DEPTH) using the count before any same-cycle pop; no push into a full queue even when popping.
REQ-017 Per FU, broadcasts SHALL occur in push order; no entry is ever duplicated or lost except by flush.
REQ-018 At most one entry is granted per cycle among non-empty queue heads.
REQ-019 Arbitration SHALL be round-robin, search order ALU->MEM->BR starting at the pointer; pointer moves to the source after the granted one; unchanged when nothing granted.
REQ-020 The granted head is popped and loaded into the cdb registers on the same edge; cdb_valid=1 for exactly the following cycle per entry.
REQ-021 cdb_valid SHALL be 0 in any cycle following an edge with no grant; cdb_pd/rob/data/src hold their last values then.
REQ-022 Latency: input sampled at edge N is broadcast earliest in the cycle after edge N+1 (2 cycles); an empty queue is not bypassed.
REQ-023 Age(t) = (t - rob_head) mod 32, unsigned 5-bit; smaller age = older.
REQ-024 On an edge with flush=1, every queued entry and every same-edge incoming push with Age(rob) > Age(flush_tag) SHALL be discarded.
REQ-025 The entry with rob == flush_tag SHALL survive and be broadcast normally.
REQ-026 Discarded entries SHALL not be granted on the flush edge; survivors are compacted, order kept, counts updated at that edge.
REQ-027 A broadcast already visible in the flush cycle is not retracted.
REQ-028 With no flush, input values on a non-accepted cycle (x_ready=0) SHALL be ignored; FUs hold offers.

Reset
REQ-029 While reset_n=0: all queues empty, RR pointer=ALU, cdb_valid=0, cdb_pd/rob/data/src=0, alu/mem/br_ready=1.
REQ-030 Reset asserted mid-operation SHALL clear state immediately (asynchronously); no queued entry is broadcast after release.

Verification
REQ-031 Single push: ALU pd=0x05 rob=3 data=0xDEADBEEF at edge 1 -> cdb_valid=1 in cycle after edge 2 with pd=0x05 rob=3 data=0xDEADBEEF src=0, then 0.
REQ-032 Simultaneous: ALU/MEM/BR push at one edge, pointer=ALU -> three consecutive broadcasts src 0,1,2; pointer returns to ALU.
REQ-033 Backpressure: all three valid held continuously with distinct rob tags -> each ready drops once queue holds DEPTH entries; each FU then accepted once per 3 cycles; per-FU order preserved, no loss.
REQ-034 Flush wrap: rob_head=30, queued ALU rob=1, MEM rob=31, BR rob=0, flush=1 flush_tag=0 -> rob 1 dropped, rob 31 and rob 0 broadcast, ALU queue count 0.
REQ-035 Flush vs push: flush_tag=5, rob_head=0, ALU push rob=7 same edge -> not enqueued; same case with rob=4 -> enqueued and broadcast.
REQ-036 Reset mid-op: all queues full, reset_n low between edges -> cdb_valid=0 and readys=1 immediately; no cdb_valid after release until new pushes.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three per-FU result FIFOs, round-robin grant into a registered
// broadcast, with mispredict flush that kills entries younger than the flushing branch.
module cdb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned PREG_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              alu_valid,
    input  logic [PREG_W-1:0] alu_pd,
    input  logic [4:0]        alu_rob,
    input  logic [31:0]       alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [PREG_W-1:0] mem_pd,
    input  logic [4:0]        mem_rob,
    input  logic [31:0]       mem_data,
    output logic              mem_ready,

    input  logic              br_valid,
    input  logic [PREG_W-1:0] br_pd,
    input  logic [4:0]        br_rob,
    input  logic [31:0]       br_data,
    output logic              br_ready,

    input  logic              flush,
    input  logic [4:0]        flush_tag,
    input  logic [4:0]        rob_head,

    output logic              cdb_valid,
    output logic [PREG_W-1:0] cdb_pd,
    output logic [4:0]        cdb_rob,
    output logic [31:0]       cdb_data,
    output logic [1:0]        cdb_src
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PREG_W-1:0] pd;
        logic [4:0]        rob;
        logic [31:0]       data;
    } entry_t;

    entry_t        q_q   [3][DEPTH];
    entry_t        q_d   [3][DEPTH];
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [1:0]    rr_q, rr_d;
    logic          cdb_valid_q, cdb_valid_d;
    entry_t        cdb_q, cdb_d;
    logic [1:0]    src_q, src_d;

    entry_t        in_e  [3];
    logic [2:0]    in_valid;
    logic [2:0]    ready;
    entry_t        comp  [3][DEPTH];
    logic [CW-1:0] keep_cnt [3];
    logic [2:0]    non_empty;
    logic          grant;
    logic [1:0]    gsrc;

    // Younger than the mispredicted branch, measured as distance from the ROB head.
    function automatic logic killed(input logic [4:0] rob, input logic [4:0] head,
                                    input logic [4:0] tag, input logic fl);
        logic [4:0] age_e;
        logic [4:0] age_f;
        age_e = rob - head;
        age_f = tag - head;
        return fl && (age_e > age_f);
    endfunction

    always_comb begin
        in_e[0]  = {alu_pd, alu_rob, alu_data};
        in_e[1]  = {mem_pd, mem_rob, mem_data};
        in_e[2]  = {br_pd, br_rob, br_data};
        in_valid = {br_valid, mem_valid, alu_valid};
        for (int s = 0; s < 3; s++) begin
            ready[s] = cnt_q[s] < CW'(DEPTH);
        end
    end

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];
    assign br_ready  = ready[2];

    // Drop killed entries and close the gaps, keeping push order.
    always_comb begin
        int rank;
        rank = 0;
        for (int s = 0; s < 3; s++) begin
            for (int j = 0; j < DEPTH; j++) begin
                comp[s][j] = q_q[s][j];
            end
            rank = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (i < int'(cnt_q[s]) && !killed(q_q[s][i].rob, rob_head, flush_tag, flush)) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == rank) comp[s][j] = q_q[s][i];
                    end
                    rank = rank + 1;
                end
            end
            keep_cnt[s]  = CW'(rank);
            non_empty[s] = (rank != 0);
        end
    end

    always_comb begin
        grant = 1'b0;
        gsrc  = 2'd0;
        case (rr_q)
            2'd1: begin
                if (non_empty[1])      begin grant = 1'b1; gsrc = 2'd1; end
                else if (non_empty[2]) begin grant = 1'b1; gsrc = 2'd2; end
                else if (non_empty[0]) begin grant = 1'b1; gsrc = 2'd0; end
            end
            2'd2: begin
                if (non_empty[2])      begin grant = 1'b1; gsrc = 2'd2; end
                else if (non_empty[0]) begin grant = 1'b1; gsrc = 2'd0; end
                else if (non_empty[1]) begin grant = 1'b1; gsrc = 2'd1; end
            end
            default: begin
                if (non_empty[0])      begin grant = 1'b1; gsrc = 2'd0; end
                else if (non_empty[1]) begin grant = 1'b1; gsrc = 2'd1; end
                else if (non_empty[2]) begin grant = 1'b1; gsrc = 2'd2; end
            end
        endcase
        rr_d = rr_q;
        if (grant) rr_d = (gsrc == 2'd2) ? 2'd0 : gsrc + 2'd1;
    end

    always_comb begin
        logic pop;
        logic push;
        int   after;
        pop         = 1'b0;
        push        = 1'b0;
        after       = 0;
        cdb_valid_d = grant;
        cdb_d       = cdb_q;
        src_d       = src_q;
        for (int s = 0; s < 3; s++) begin
            pop = grant && (gsrc == 2'(s));
            for (int j = 0; j < DEPTH; j++) begin
                q_d[s][j] = comp[s][j];
            end
            if (pop) begin
                for (int j = 0; j < int'(DEPTH) - 1; j++) begin
                    q_d[s][j] = comp[s][j+1];
                end
                cdb_d = comp[s][0];
                src_d = 2'(s);
            end
            after = int'(keep_cnt[s]) - (pop ? 1 : 0);
            // Ready is judged on the pre-pop count, so a full queue never takes a push.
            push  = in_valid[s] && ready[s] && !killed(in_e[s].rob, rob_head, flush_tag, flush);
            for (int j = 0; j < DEPTH; j++) begin
                if (push && j == after) q_d[s][j] = in_e[s];
            end
            cnt_d[s] = CW'(after + (push ? 1 : 0));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 3; s++) begin
                cnt_q[s] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    q_q[s][j] <= '0;
                end
            end
            rr_q        <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
            src_q       <= 2'd0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                cnt_q[s] <= cnt_d[s];
                for (int j = 0; j < DEPTH; j++) begin
                    q_q[s][j] <= q_d[s][j];
                end
            end
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
            src_q       <= src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_pd    = cdb_q.pd;
    assign cdb_rob   = cdb_q.rob;
    assign cdb_data  = cdb_q.data;
    assign cdb_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single push, round-robin, backpressure, flush, mid-op reset.
module tb_cdb_arbiter;

    localparam int DEPTH  = 2;
    localparam int PREG_W = 7;

    logic              clk;
    logic              reset_n;
    logic              alu_valid, mem_valid, br_valid;
    logic [PREG_W-1:0] alu_pd, mem_pd, br_pd;
    logic [4:0]        alu_rob, mem_rob, br_rob;
    logic [31:0]       alu_data, mem_data, br_data;
    logic              alu_ready, mem_ready, br_ready;
    logic              flush;
    logic [4:0]        flush_tag;
    logic [4:0]        rob_head;
    logic              cdb_valid;
    logic [PREG_W-1:0] cdb_pd;
    logic [4:0]        cdb_rob;
    logic [31:0]       cdb_data;
    logic [1:0]        cdb_src;

    int tests_run    = 0;
    int tests_failed = 0;

    cdb_arbiter #(
        .DEPTH  (DEPTH),
        .PREG_W (PREG_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_pd    (alu_pd),
        .alu_rob   (alu_rob),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_pd    (mem_pd),
        .mem_rob   (mem_rob),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .br_valid  (br_valid),
        .br_pd     (br_pd),
        .br_rob    (br_rob),
        .br_data   (br_data),
        .br_ready  (br_ready),
        .flush     (flush),
        .flush_tag (flush_tag),
        .rob_head  (rob_head),
        .cdb_valid (cdb_valid),
        .cdb_pd    (cdb_pd),
        .cdb_rob   (cdb_rob),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; alu_pd = '0; alu_rob = '0; alu_data = '0;
        mem_valid = 1'b0; mem_pd = '0; mem_rob = '0; mem_data = '0;
        br_valid  = 1'b0; br_pd  = '0; br_rob  = '0; br_data  = '0;
        flush     = 1'b0; flush_tag = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rob_head = '0;
        reset_n  = 1'b0;
        step();
        step();
        reset_n  = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rob_head = '0;
        reset_n  = 1'b1;
        #1;
        reset_n  = 1'b0;
        #1;
        tests_run++;
        if ({cdb_valid, cdb_src, cdb_pd, cdb_rob, cdb_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_cdb: got v=%b src=%0d pd=%h rob=%0d data=%h want all 0",
                     cdb_valid, cdb_src, cdb_pd, cdb_rob, cdb_data);
        end
        tests_run++;
        if ({alu_ready, mem_ready, br_ready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 111", {alu_ready, mem_ready, br_ready});
        end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        alu_valid = 1'b1; alu_pd = 7'h05; alu_rob = 5'd3; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        tests_run++;
        if (cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_no_bypass: got valid=%b want 0", cdb_valid);
        end
        step();
        tests_run++;
        if ({cdb_valid, cdb_pd, cdb_rob, cdb_data, cdb_src} !==
            {1'b1, 7'h05, 5'd3, 32'hDEADBEEF, 2'd0}) begin
            tests_failed++;
            $display("FAIL single_bcast: got v=%b pd=%h rob=%0d data=%h src=%0d want 1 05 3 deadbeef 0",
                     cdb_valid, cdb_pd, cdb_rob, cdb_data, cdb_src);
        end
        step();
        tests_run++;
        if ({cdb_valid, cdb_pd, cdb_data} !== {1'b0, 7'h05, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL single_hold: got v=%b pd=%h data=%h want 0 05 deadbeef",
                     cdb_valid, cdb_pd, cdb_data);
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_data [3];
        exp_data[0] = 32'hA0A0_0001;
        exp_data[1] = 32'hB0B0_0002;
        exp_data[2] = 32'hC0C0_0003;
        do_reset();
        alu_valid = 1'b1; alu_rob = 5'd1; alu_data = exp_data[0];
        mem_valid = 1'b1; mem_rob = 5'd2; mem_data = exp_data[1];
        br_valid  = 1'b1; br_rob  = 5'd3; br_data  = exp_data[2];
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if ({cdb_valid, cdb_src, cdb_data} !== {1'b1, 2'(k), exp_data[k]}) begin
                tests_failed++;
                $display("FAIL rr_order%0d: got v=%b src=%0d data=%h want 1 %0d %h",
                         k, cdb_valid, cdb_src, cdb_data, k, exp_data[k]);
            end
        end
        step();
        tests_run++;
        if (cdb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_idle: got valid=%b want 0", cdb_valid);
        end
        // Pointer should be back at ALU: MEM must wait behind a simultaneous ALU offer.
        mem_valid = 1'b1; mem_rob = 5'd9; mem_data = 32'h0000_0009;
        alu_valid = 1'b1; alu_rob = 5'd8; alu_data = 32'h0000_0008;
        step();
        idle_inputs();
        step();
        tests_run++;
        if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 2'd0, 5'd8}) begin
            tests_failed++;
            $display("FAIL rr_ptr_wrap: got v=%b src=%0d rob=%0d want 1 0 8",
                     cdb_valid, cdb_src, cdb_rob);
        end
        step();
        tests_run++;
        if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 2'd1, 5'd9}) begin
            tests_failed++;
            $display("FAIL rr_second: got v=%b src=%0d rob=%0d want 1 1 9",
                     cdb_valid, cdb_src, cdb_rob);
        end
    endtask

    task automatic test_backpressure;
        int         seq [3];
        int         rcv [3];
        int         win [3];
        logic [2:0] acc;
        for (int s = 0; s < 3; s++) begin
            seq[s] = 0; rcv[s] = 0; win[s] = 0;
        end
        do_reset();
        for (int c = 0; c < 70; c++) begin
            if (c < 60) begin
                alu_valid = 1'b1; alu_pd = 7'(seq[0]); alu_rob = 5'(3 * seq[0]);
                alu_data = {8'd0, 24'(seq[0])};
                mem_valid = 1'b1; mem_pd = 7'(seq[1]); mem_rob = 5'(3 * seq[1] + 1);
                mem_data = {8'd1, 24'(seq[1])};
                br_valid  = 1'b1; br_pd  = 7'(seq[2]); br_rob  = 5'(3 * seq[2] + 2);
                br_data  = {8'd2, 24'(seq[2])};
            end else begin
                idle_inputs();
            end
            acc = {br_valid & br_ready, mem_valid & mem_ready, alu_valid & alu_ready};
            step();
            for (int s = 0; s < 3; s++) begin
                if (acc[s]) begin
                    seq[s]++;
                    if (c >= 10 && c < 40) win[s]++;
                end
            end
            if (c == 1) begin
                tests_run++;
                if ({alu_ready, mem_ready, br_ready} !== 3'b100) begin
                    tests_failed++;
                    $display("FAIL bp_ready_drop: got %b want 100",
                             {alu_ready, mem_ready, br_ready});
                end
            end
            if (cdb_valid === 1'b1) begin
                tests_run++;
                if (cdb_src == 2'd3) begin
                    tests_failed++;
                    $display("FAIL bp_src: got src=3 want 0..2");
                end else begin
                    if (cdb_data !== {8'(cdb_src), 24'(rcv[cdb_src])}) begin
                        tests_failed++;
                        $display("FAIL bp_order: got data=%h want %h", cdb_data,
                                 {8'(cdb_src), 24'(rcv[cdb_src])});
                    end
                    rcv[cdb_src]++;
                end
            end
        end
        for (int s = 0; s < 3; s++) begin
            tests_run++;
            if (rcv[s] != seq[s]) begin
                tests_failed++;
                $display("FAIL bp_no_loss%0d: got %0d broadcasts want %0d", s, rcv[s], seq[s]);
            end
            tests_run++;
            if (win[s] != 10) begin
                tests_failed++;
                $display("FAIL bp_rate%0d: got %0d accepts in 30 cycles want 10", s, win[s]);
            end
        end
    endtask

    task automatic test_flush_wrap;
        do_reset();
        rob_head  = 5'd30;
        alu_valid = 1'b1; alu_rob = 5'd1;  alu_data = 32'h1;
        mem_valid = 1'b1; mem_rob = 5'd31; mem_data = 32'h31;
        br_valid  = 1'b1; br_rob  = 5'd0;  br_data  = 32'h0;
        step();
        idle_inputs();
        flush = 1'b1; flush_tag = 5'd0;
        step();
        idle_inputs();
        tests_run++;
        if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 2'd1, 5'd31}) begin
            tests_failed++;
            $display("FAIL flush_wrap_mem: got v=%b src=%0d rob=%0d want 1 1 31",
                     cdb_valid, cdb_src, cdb_rob);
        end
        step();
        tests_run++;
        if ({cdb_valid, cdb_src, cdb_rob} !== {1'b1, 2'd2, 5'd0}) begin
            tests_failed++;
            $display("FAIL flush_wrap_br: got v=%b src=%0d rob=%0d want 1 2 0",
                     cdb_valid, cdb_src, cdb_rob);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            tests_run++;
            if (cdb_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_wrap_alu_dropped%0d: got valid=%b src=%0d want 0",
                         k, cdb_valid, cdb_src);
            end
        end
    endtask

    task automatic test_flush_push;
        do_reset();
        rob_head  = 5'd0;
        flush = 1'b1; flush_tag = 5'd5;
        alu_valid = 1'b1; alu_rob = 5'd7; alu_data = 32'h7;
        step();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            step();
            tests_run++;
            if (cdb_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_push_young%0d: got valid=%b want 0", k, cdb_valid);
            end
        end
        flush = 1'b1; flush_tag = 5'd5;
        alu_valid = 1'b1; alu_rob = 5'd4; alu_data = 32'h4;
        step();
        idle_inputs();
        step();
        tests_run++;
        if ({cdb_valid, cdb_src, cdb_rob, cdb_data} !== {1'b1, 2'd0, 5'd4, 32'h4}) begin
            tests_failed++;
            $display("FAIL flush_push_old: got v=%b src=%0d rob=%0d data=%h want 1 0 4 4",
                     cdb_valid, cdb_src, cdb_rob, cdb_data);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        alu_valid = 1'b1; alu_rob = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rob = 5'd2; mem_data = 32'h22;
        br_valid  = 1'b1; br_rob  = 5'd3; br_data  = 32'h33;
        for (int k = 0; k < 3; k++) step();
        tests_run++;
        if (cdb_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_busy: got valid=%b want 1", cdb_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({cdb_valid, alu_ready, mem_ready, br_ready} !== 4'b0111) begin
            tests_failed++;
            $display("FAIL mid_async: got v=%b ready=%b want 0 111",
                     cdb_valid, {alu_ready, mem_ready, br_ready});
        end
        idle_inputs();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            tests_run++;
            if (cdb_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_after_release%0d: got valid=%b want 0", k, cdb_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush_wrap();
        test_flush_push();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
